// File: rtl/im_fetch_responder.sv
// Instruction-fetch responder: word store with fixed response latency,
// AdEL detection on bad fetch addresses and flush of in-flight fetches.
module im_fetch_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int          DEPTH       = 4096,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [31:0]              req_addr,
    output logic                     req_ready,
    input  logic                     flush,
    output logic                     resp_valid,
    output logic [31:0]              resp_instr,
    output logic [31:0]              resp_addr,
    output logic                     resp_adel,
    input  logic                     load_we,
    input  logic [$clog2(DEPTH)-1:0] load_idx,
    input  logic [31:0]              load_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
    localparam logic [AW-1:0] BASE_IDX = BASE_ADDR[AW+1:2];
    localparam logic [3:0] WLOAD =
        (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic [31:0]   addr_q;
    logic [31:0]   instr_q;
    logic          adel_q;

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          adel;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;

    assign req_ready  = (state_q == IDLE || state_q == RESP) && !flush;
    assign resp_valid = (state_q == RESP) && !flush;
    assign accept     = req_valid && req_ready;

    // 33-bit limit compare so the end of the store cannot wrap past 2^32
    assign adel = (req_addr[1:0] != 2'b00)
               || (req_addr < BASE_ADDR)
               || ({1'b0, req_addr} >= LIMIT);

    assign idx     = req_addr[AW+1:2] - BASE_IDX;
    assign rd_word = adel ? 32'h0 : mem[idx];

    assign resp_instr = instr_q;
    assign resp_addr  = addr_q;
    assign resp_adel  = adel_q;

    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_idx] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            instr_q <= 32'h0;
            adel_q  <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            unique case (state_q)
                IDLE, RESP: begin
                    if (accept) begin
                        addr_q  <= req_addr;
                        adel_q  <= adel;
                        instr_q <= rd_word;
                        cnt_q   <= WLOAD;
                        state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_fetch_responder.sv
// Bench for im_fetch_responder: three latency variants on shared stimulus,
// checked each cycle against a pending-response model.
module tb_im_fetch_responder;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        flush;
    logic        load_we;
    logic [11:0] load_idx;
    logic [31:0] load_data;

    logic [N-1:0]       rdy;
    logic [N-1:0]       rv;
    logic [N-1:0]       adl;
    logic [N-1:0][31:0] ri;
    logic [N-1:0][31:0] ra;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : gd
            im_fetch_responder #(
                .BASE_ADDR  (32'h0000_3000),
                .DEPTH      (4096),
                .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 2 : 3))
            ) dut (
                .clk       (clk),
                .reset     (reset),
                .req_valid (req_valid),
                .req_addr  (req_addr),
                .req_ready (rdy[g]),
                .flush     (flush),
                .resp_valid(rv[g]),
                .resp_instr(ri[g]),
                .resp_addr (ra[g]),
                .resp_adel (adl[g]),
                .load_we   (load_we),
                .load_idx  (load_idx),
                .load_data (load_data)
            );
        end
    endgenerate

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Model: at most one outstanding fetch per instance, answered when
    // its remaining-latency count reaches zero.
    bit          p_v    [N];
    int          p_left [N];
    logic [31:0] p_addr [N];
    logic [31:0] p_instr[N];
    bit          p_adel [N];
    logic [31:0] shadow [4096];

    initial begin
        for (int d = 0; d < N; d++) p_v[d] = 0;
    end

    function automatic int wc_of(int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    function automatic bit m_adel(logic [31:0] a);
        longint u;
        u = longint'(a);
        return (u % 4 != 0) || (u < 64'h3000) || (u >= 64'h3000 + 4 * 4096);
    endfunction

    function automatic bit m_rdy(int d);
        return !flush && (!p_v[d] || p_left[d] == 0);
    endfunction

    function automatic bit m_rv(int d);
        return !flush && p_v[d] && p_left[d] == 0;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        bit acc[N];
        for (int d = 0; d < N; d++) acc[d] = req_valid && m_rdy(d);
        for (int d = 0; d < N; d++) begin
            if (reset || flush) begin
                p_v[d] = 0;
            end else begin
                if (p_v[d]) begin
                    if (p_left[d] == 0) p_v[d] = 0;
                    else p_left[d]--;
                end
                if (acc[d]) begin
                    p_v[d]    = 1;
                    p_left[d] = wc_of(d);
                    p_addr[d] = req_addr;
                    p_adel[d] = m_adel(req_addr);
                    if (p_adel[d]) p_instr[d] = 32'h0;
                    else p_instr[d] = shadow[int'((req_addr - 32'h3000) >> 2)];
                end
            end
        end
        if (load_we) shadow[load_idx] = load_data;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < N; d++) begin
                chk($sformatf("ready d%0d", d), 32'(rdy[d]), 32'(m_rdy(d)));
                chk($sformatf("valid d%0d", d), 32'(rv[d]), 32'(m_rv(d)));
                if (m_rv(d)) begin
                    chk($sformatf("addr d%0d", d), ra[d], p_addr[d]);
                    chk($sformatf("instr d%0d", d), ri[d], p_instr[d]);
                    chk($sformatf("adel d%0d", d), 32'(adl[d]), 32'(p_adel[d]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 5))
            0: a = 32'h3000 + 32'(4 * $urandom_range(0, 15));
            1: a = 32'h3000 + 32'(4 * $urandom_range(0, 4095));
            2: a = 32'h3000 + 32'(4 * $urandom_range(0, 4095))
                   + 32'($urandom_range(1, 3));
            3: a = 32'($urandom_range(0, 32'h2fff));
            4: a = 32'h7000 + ($urandom & 32'h0fff_fffc);
            default: begin
                case ($urandom_range(0, 3))
                    0: a = 32'h6ffc;
                    1: a = 32'h7000;
                    2: a = 32'h2ffc;
                    default: a = 32'h3000;
                endcase
            end
        endcase
        return a;
    endfunction

    logic [31:0] t3a[4];
    bit          t3e[4];

    initial begin
        reset = 1; req_valid = 0; req_addr = 0; flush = 0;
        load_we = 0; load_idx = 0; load_data = 0;
        step();
        step();
        chk_en = 1;
        for (int d = 0; d < N; d++) begin
            chk($sformatf("rst addr d%0d", d), ra[d], 32'h0);
            chk($sformatf("rst instr d%0d", d), ri[d], 32'h0);
            chk($sformatf("rst adel d%0d", d), 32'(adl[d]), 32'h0);
            chk($sformatf("rst valid d%0d", d), 32'(rv[d]), 32'h0);
        end
        reset = 0;

        for (int i = 0; i < 4096; i++) begin
            load_we  = 1;
            load_idx = 12'(i);
            if (i == 0) load_data = 32'h3c01_0001;
            else if (i == 1) load_data = 32'h3421_0002;
            else if (i == 4) load_data = 32'h1234_5678;
            else load_data = $urandom;
            step();
        end
        load_we = 0;

        // back-to-back fetches at zero latency
        req_valid = 1; req_addr = 32'h3000;
        step();
        chk("t1 valid0", 32'(rv[0]), 32'h1);
        chk("t1 instr0", ri[0], 32'h3c01_0001);
        chk("t1 adel0", 32'(adl[0]), 32'h0);
        req_addr = 32'h3004;
        step();
        chk("t1 valid1", 32'(rv[0]), 32'h1);
        chk("t1 instr1", ri[0], 32'h3421_0002);
        chk("t1 addr1", ra[0], 32'h3004);
        req_valid = 0;
        idle(6);

        // two wait states
        req_valid = 1; req_addr = 32'h3008;
        step();
        req_valid = 0;
        chk("t2 ready w1", 32'(rdy[1]), 32'h0);
        chk("t2 valid w1", 32'(rv[1]), 32'h0);
        step();
        chk("t2 ready w2", 32'(rdy[1]), 32'h0);
        chk("t2 valid w2", 32'(rv[1]), 32'h0);
        step();
        chk("t2 valid", 32'(rv[1]), 32'h1);
        chk("t2 addr", ra[1], 32'h3008);
        step();
        chk("t2 pulse end", 32'(rv[1]), 32'h0);
        idle(4);

        // address errors and the last valid word
        t3a = '{32'h3002, 32'h2ffc, 32'h7000, 32'h6ffc};
        t3e = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            req_valid = 1; req_addr = t3a[i];
            step();
            req_valid = 0;
            chk($sformatf("t3 valid %h", t3a[i]), 32'(rv[0]), 32'h1);
            chk($sformatf("t3 adel %h", t3a[i]), 32'(adl[0]), 32'(t3e[i]));
            if (t3e[i]) chk($sformatf("t3 instr %h", t3a[i]), ri[0], 32'h0);
            idle(5);
        end

        // flush in the second wait cycle of a three-wait fetch
        req_valid = 1; req_addr = 32'h3010;
        step();
        req_valid = 0;
        step();
        flush = 1;
        #1;
        chk("t4 ready flush", 32'(rdy[2]), 32'h0);
        step();
        flush = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t4 no resp", 32'(rv[2]), 32'h0);
            step();
        end
        req_valid = 1; req_addr = 32'h4180;
        step();
        req_valid = 0;
        step();
        step();
        chk("t4 early", 32'(rv[2]), 32'h0);
        step();
        chk("t4 valid", 32'(rv[2]), 32'h1);
        chk("t4 addr", ra[2], 32'h4180);
        idle(4);

        // flush during the response cycle
        req_valid = 1; req_addr = 32'h3000;
        step();
        flush = 1;
        #1;
        chk("t5 valid", 32'(rv[0]), 32'h0);
        chk("t5 ready", 32'(rdy[0]), 32'h0);
        step();
        flush = 0; req_valid = 0;
        #1;
        chk("t5 idle valid", 32'(rv[0]), 32'h0);
        chk("t5 idle ready", 32'(rdy[0]), 32'h1);
        idle(4);

        // read-before-write on a same-cycle load
        load_we = 1; load_idx = 12'd4; load_data = 32'hffff_ffff;
        req_valid = 1; req_addr = 32'h3010;
        step();
        load_we = 0; req_valid = 0;
        chk("t6 old", ri[0], 32'h1234_5678);
        idle(5);
        req_valid = 1; req_addr = 32'h3010;
        step();
        req_valid = 0;
        chk("t6 new", ri[0], 32'hffff_ffff);
        idle(5);

        // reset in the middle of a wait
        req_valid = 1; req_addr = 32'h3002;
        step();
        req_valid = 0;
        step();
        reset = 1;
        step();
        reset = 0;
        chk("t6 rst adel", 32'(adl[2]), 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("t6 rst no resp", 32'(rv[2]), 32'h0);
            step();
        end

        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            req_valid = ($urandom_range(0, 9) < 7);
            req_addr  = rand_addr();
            load_we   = ($urandom_range(0, 9) == 0);
            load_idx  = ($urandom_range(0, 3) == 0) ? 12'($urandom)
                                                    : 12'($urandom_range(0, 15));
            load_data = $urandom;
            step();
        end
        reset = 0; flush = 0; req_valid = 0; load_we = 0;
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
